ioddr_loopback_sequencer: RTL and testbench

Sequences a self-checking IDDR/ODDR loopback test. It drives a pseudo-random 2-bit-per-cycle pattern into the ODDR data pins and samples the IDDR outputs. It searches for the loopback latency, locks to it, then compares a fixed number of cycles and reports pass/fail with an error count. It sits between the ODDR/IDDR wrappers in loopback builds and the board-level status/LED logic.

---
 rtl/ioddr_loopback_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ioddr_loopback_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ioddr_loopback_sequencer.sv
// -----------------------------------------------------------------------------
// ioddr_loopback_sequencer
//
// Purpose:
//    Drives a pseudo-random 2-bit-per-cycle pattern into an ODDR and watches
//    the IDDR outputs of a loopback path. It first lets the path fill (FLUSH),
//    then searches latencies 0..MAX_LAT for ALIGN_LEN consecutive matching
//    cycles (ALIGN), then compares CHECK_LEN cycles at the locked latency
//    (CHECK), and finally reports the result (DONE).
//
// Ports:
//    CLK      clock, rising edge
//    RST      synchronous active-low reset
//    START    level; starts a run from IDLE or DONE
//    D1, D2   registered ODDR first/second-edge data
//    Q1, Q2   IDDR first/second-edge data (compared combinationally)
//    BUSY     high in FLUSH/ALIGN/CHECK
//    DONE     high in DONE
//    LOCKED   a latency was found
//    LATENCY  locked latency in CLK cycles
//    PASS     valid in DONE; locked and zero bit errors
//    ERR_CNT  saturating bit-error count of the CHECK phase
// -----------------------------------------------------------------------------
module ioddr_loopback_sequencer #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          MAX_LAT   = 8,
   parameter int          ALIGN_LEN = 32,
   parameter int          CHECK_LEN = 1024,
   parameter int          ERR_W     = 16
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         START,
   output logic                         D1,
   output logic                         D2,
   input  logic                         Q1,
   input  logic                         Q2,
   output logic                         BUSY,
   output logic                         DONE,
   output logic                         LOCKED,
   output logic [$clog2(MAX_LAT+1)-1:0] LATENCY,
   output logic                         PASS,
   output logic [ERR_W-1:0]             ERR_CNT
);

   localparam int LAT_W = $clog2(MAX_LAT + 1);
   // An all-zero seed would lock the LFSR at zero forever.
   localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam int CNT_MAX = (CHECK_LEN > ALIGN_LEN)
                          ? ((CHECK_LEN > MAX_LAT) ? CHECK_LEN : MAX_LAT)
                          : ((ALIGN_LEN > MAX_LAT) ? ALIGN_LEN : MAX_LAT);
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam int SUM_W = ERR_W + 1;
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FLUSH = 3'd1,
      ST_ALIGN = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // One Fibonacci step: taps 16,14,13,11 (bits 15,13,12,10).
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      lfsr_step = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Adds the number of differing bits (0..2) and clamps at all-ones.
   function automatic logic [ERR_W-1:0] err_sat_add(input logic [ERR_W-1:0] acc,
                                                    input logic [1:0]       diff);
      logic [SUM_W-1:0] sum;
      sum = {1'b0, acc} + SUM_W'(diff[1]) + SUM_W'(diff[0]);
      // Increment is at most 2, so any carry out means the true sum exceeded ERR_MAX.
      if (sum[ERR_W]) begin
         err_sat_add = ERR_MAX;
      end else begin
         err_sat_add = sum[ERR_W-1:0];
      end
   endfunction

   function automatic logic is_busy(input state_t s);
      is_busy = (s == ST_FLUSH) || (s == ST_ALIGN) || (s == ST_CHECK);
   endfunction

   state_t             state_q, state_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic               d1_q, d1_d;
   logic               d2_q, d2_d;
   // hist_q[k] holds the pin pair from k+1 cycles ago; the current pair is {d1_q, d2_q}.
   logic [1:0]         hist_q [0:MAX_LAT-1];
   logic [1:0]         hist_d [0:MAX_LAT-1];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LAT_W-1:0]   lat_try_q, lat_try_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               locked_q, locked_d;
   logic [LAT_W-1:0]   latency_q, latency_d;
   logic               pass_q, pass_d;
   logic [ERR_W-1:0]   err_q, err_d;

   logic [LAT_W-1:0]   lat_sel_s;
   logic [1:0]         ref_s;
   logic [1:0]         diff_s;
   logic               match_s;
   logic [ERR_W-1:0]   err_next_s;

   // Select the expected pin pair for the latency under test and compare with the IDDR.
   always_comb begin
      lat_sel_s = (state_q == ST_CHECK) ? latency_q : lat_try_q;
      ref_s     = (lat_sel_s == LAT_W'(0)) ? {d1_q, d2_q} : 2'b00;
      for (int k = 1; k <= MAX_LAT; k++) begin
         ref_s = ref_s | ((lat_sel_s == LAT_W'(k)) ? hist_q[k-1] : 2'b00);
      end
      diff_s     = {Q1, Q2} ^ ref_s;
      match_s    = (diff_s == 2'b00);
      err_next_s = err_sat_add(err_q, diff_s);
   end

   // Next-state, counters, pattern generation and result registers.
   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      d1_d      = 1'b0;
      d2_d      = 1'b0;
      hist_d    = hist_q;
      cnt_d     = cnt_q;
      lat_try_d = lat_try_q;
      locked_d  = locked_q;
      latency_d = latency_q;
      pass_d    = pass_q;
      err_d     = err_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               state_d   = ST_FLUSH;
               lfsr_d    = SEED;
               cnt_d     = {CNT_W{1'b0}};
               lat_try_d = {LAT_W{1'b0}};
               locked_d  = 1'b0;
               latency_d = {LAT_W{1'b0}};
               pass_d    = 1'b0;
               err_d     = {ERR_W{1'b0}};
               for (int k = 0; k < MAX_LAT; k++) begin
                  hist_d[k] = 2'b00;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_FLUSH: begin
            // MAX_LAT+1 cycles so every history slot holds pattern data before aligning.
            if (cnt_q == CNT_W'(MAX_LAT)) begin
               state_d   = ST_ALIGN;
               cnt_d     = {CNT_W{1'b0}};
               lat_try_d = {LAT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_ALIGN: begin
            if (match_s) begin
               if (cnt_q == CNT_W'(ALIGN_LEN - 1)) begin
                  state_d   = ST_CHECK;
                  locked_d  = 1'b1;
                  latency_d = lat_try_q;
                  cnt_d     = {CNT_W{1'b0}};
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (lat_try_q == LAT_W'(MAX_LAT)) begin
               state_d  = ST_DONE;
               locked_d = 1'b0;
               pass_d   = 1'b0;
            end else begin
               cnt_d     = {CNT_W{1'b0}};
               lat_try_d = lat_try_q + LAT_W'(1);
            end
         end
         ST_CHECK: begin
            err_d = err_next_s;
            if (cnt_q == CNT_W'(CHECK_LEN - 1)) begin
               state_d = ST_DONE;
               // Uses the updated count so the final cycle's errors are included.
               pass_d  = (err_next_s == {ERR_W{1'b0}});
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pattern and history advance only while a run is active; pins go quiet on exit.
      if (is_busy(state_q)) begin
         lfsr_d    = lfsr_step(lfsr_step(lfsr_q));
         hist_d[0] = {d1_q, d2_q};
         for (int k = 1; k < MAX_LAT; k++) begin
            hist_d[k] = hist_q[k-1];
         end
         if (is_busy(state_d)) begin
            d1_d = lfsr_q[15];
            d2_d = lfsr_q[14];
         end else begin
            d1_d = 1'b0;
            d2_d = 1'b0;
         end
      end else begin
         d1_d = 1'b0;
         d2_d = 1'b0;
      end

      busy_d = is_busy(state_d);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         lfsr_q    <= SEED;
         d1_q      <= 1'b0;
         d2_q      <= 1'b0;
         for (int k = 0; k < MAX_LAT; k++) begin
            hist_q[k] <= 2'b00;
         end
         cnt_q     <= {CNT_W{1'b0}};
         lat_try_q <= {LAT_W{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         locked_q  <= 1'b0;
         latency_q <= {LAT_W{1'b0}};
         pass_q    <= 1'b0;
         err_q     <= {ERR_W{1'b0}};
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         hist_q    <= hist_d;
         cnt_q     <= cnt_d;
         lat_try_q <= lat_try_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         locked_q  <= locked_d;
         latency_q <= latency_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
      end
   end

   assign D1      = d1_q;
   assign D2      = d2_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign LOCKED  = locked_q;
   assign LATENCY = latency_q;
   assign PASS    = pass_q;
   assign ERR_CNT = err_q;

endmodule

// File: tb/tb_ioddr_loopback_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ioddr_loopback_sequencer
//
// Purpose:
//    Directed bench for ioddr_loopback_sequencer. A loopback model delays the
//    DUT's pin pair by a chosen latency (or ties Q low) and can flip bits on
//    chosen CHECK cycles. A second instance with ERR_W=4 shares the same Q so
//    error-counter saturation can be observed alongside the default instance.
// -----------------------------------------------------------------------------
module tb_ioddr_loopback_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        q1, q2;
   logic        d1, d2, busy, done, locked, pass;
   logic [3:0]  latency;
   logic [15:0] err_cnt;
   logic        d1_b, d2_b, busy_b, done_b, locked_b, pass_b;
   logic [3:0]  latency_b;
   logic [3:0]  err_b;

   int          n_checks = 0;
   int          n_fail   = 0;

   // loopback model controls
   int          lat_m;
   int          qmode;       // 0 = delayed pins, 1 = Q tied low
   logic [1:0]  err_mask;
   logic [1:0]  pin_h [1:15];
   logic [1:0]  qv;

   always #5 clk = ~clk;

   ioddr_loopback_sequencer dut (
      .CLK(clk), .RST(rst), .START(start),
      .D1(d1), .D2(d2), .Q1(q1), .Q2(q2),
      .BUSY(busy), .DONE(done), .LOCKED(locked),
      .LATENCY(latency), .PASS(pass), .ERR_CNT(err_cnt)
   );

   ioddr_loopback_sequencer #(.ERR_W(4)) dut_b (
      .CLK(clk), .RST(rst), .START(start),
      .D1(d1_b), .D2(d2_b), .Q1(q1), .Q2(q2),
      .BUSY(busy_b), .DONE(done_b), .LOCKED(locked_b),
      .LATENCY(latency_b), .PASS(pass_b), .ERR_CNT(err_b)
   );

   // Pin history of the main instance: pin_h[k] is the pair from k cycles ago.
   always @(posedge clk) begin
      pin_h[1] <= {d1, d2};
      for (int k = 2; k <= 15; k++) begin
         pin_h[k] <= pin_h[k-1];
      end
   end

   // Loopback output: delayed or grounded pattern with optional bit flips.
   always_comb begin
      qv = 2'b00;
      if (qmode == 1) begin
         qv = 2'b00;
      end else if (lat_m == 0) begin
         qv = {d1, d2};
      end else begin
         qv = pin_h[lat_m];
      end
      {q1, q2} = qv ^ err_mask;
   end

   task automatic chk(input string tag, input int got, input int expv);
      n_checks++;
      if (got != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   function automatic logic [1:0] mask_for(input int inj, input int cc);
      logic [1:0] m;
      m = 2'b00;
      if (inj == 1) begin
         if (cc == 100 || cc == 200 || cc == 300 || cc == 400 || cc == 500) m = 2'b01;
         else if (cc == 600) m = 2'b11;
      end else if (inj == 2) begin
         if (cc >= 10) m = 2'b11;
      end
      return m;
   endfunction

   // Pulse START, follow the run to DONE, injecting errors relative to CHECK start.
   task automatic run(input int inj, input bit chk_pins, output int lock_cyc, output int done_cyc);
      int cyc;
      bit seen;
      logic [1:0] exp_pins [1:3];
      exp_pins[1] = 2'b10;
      exp_pins[2] = 2'b10;
      exp_pins[3] = 2'b11;
      lock_cyc = -1;
      done_cyc = -1;
      seen = 1'b0;
      cyc = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      chk("done_clr_on_start", int'(done), 0);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         cyc++;
         if (chk_pins && cyc <= 3) chk($sformatf("pins_c%0d", cyc), int'({d1, d2}), int'(exp_pins[cyc]));
         if (!seen && locked) begin
            seen = 1'b1;
            lock_cyc = cyc;
         end
         if (done) begin
            done_cyc = cyc;
            err_mask = 2'b00;
            break;
         end
         if (seen) err_mask = mask_for(inj, cyc - lock_cyc);
      end
      err_mask = 2'b00;
      if (done_cyc < 0) chk("run_timeout", 0, 1);
      chk("busy_low_in_done", int'(busy), 0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_d1"}, int'(d1), 0);
      chk({tag, "_d2"}, int'(d2), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_latency"}, int'(latency), 0);
      chk({tag, "_pass"}, int'(pass), 0);
      chk({tag, "_err"}, int'(err_cnt), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lk, dn;
      bit seen;
      rst = 1'b0;
      start = 1'b0;
      err_mask = 2'b00;
      qmode = 0;
      lat_m = 3;
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b1;

      // latency 3 clean run
      run(0, 1'b1, lk, dn);
      chk("lat3_lock_cycle", lk, 44);
      chk("lat3_check_len", dn - lk, 1024);
      chk("lat3_locked", int'(locked), 1);
      chk("lat3_latency", int'(latency), 3);
      chk("lat3_pass", int'(pass), 1);
      chk("lat3_err", int'(err_cnt), 0);
      repeat (3) @(negedge clk);
      chk("done_hold", int'(done), 1);
      chk("done_hold_pass", int'(pass), 1);
      chk("done_hold_latency", int'(latency), 3);
      chk("done_pins_quiet", int'({d1, d2}), 0);

      // latency 0
      lat_m = 0;
      run(0, 1'b0, lk, dn);
      chk("lat0_lock_cycle", lk, 41);
      chk("lat0_latency", int'(latency), 0);
      chk("lat0_pass", int'(pass), 1);
      chk("lat0_err", int'(err_cnt), 0);

      // latency 3 with 5 single-bit and 1 double-bit error
      lat_m = 3;
      run(1, 1'b0, lk, dn);
      chk("inj7_err", int'(err_cnt), 7);
      chk("inj7_pass", int'(pass), 0);
      chk("inj7_locked", int'(locked), 1);
      chk("inj7_err_w4", int'(err_b), 7);

      // latency beyond search range
      lat_m = 9;
      run(0, 1'b0, lk, dn);
      chk("lat9_locked", int'(locked), 0);
      chk("lat9_pass", int'(pass), 0);
      chk("lat9_err", int'(err_cnt), 0);
      chk("lat9_latency", int'(latency), 0);

      // Q stuck low
      qmode = 1;
      lat_m = 3;
      run(0, 1'b0, lk, dn);
      chk("qzero_done", int'(done), 1);
      chk("qzero_locked", int'(locked), 0);
      chk("qzero_pass", int'(pass), 0);
      chk("qzero_err", int'(err_cnt), 0);
      qmode = 0;

      // both bits flipped from CHECK cycle 10: 1014 cycles x 2 bits
      run(2, 1'b0, lk, dn);
      chk("sat_err_w4", int'(err_b), 15);
      chk("sat_pass_w4", int'(pass_b), 0);
      chk("sat_err_w16", int'(err_cnt), 2028);
      chk("sat_pass_w16", int'(pass), 0);

      // reset during CHECK
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (locked) begin
            seen = 1'b1;
            break;
         end
      end
      chk("midrst_locked_first", int'(seen), 1);
      repeat (100) @(negedge clk);
      chk("midrst_busy_before", int'(busy), 1);
      rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      chk_zero_outputs("midrst");
      @(negedge clk);
      chk("midrst_idle_busy", int'(busy), 0);
      chk("midrst_idle_done", int'(done), 0);

      run(0, 1'b0, lk, dn);
      chk("after_rst_pass", int'(pass), 1);
      chk("after_rst_latency", int'(latency), 3);
      run(0, 1'b0, lk, dn);
      chk("restart_pass", int'(pass), 1);
      chk("restart_err", int'(err_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
